layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Per-pixel compositor between the draw_* shape units and palette. Takes NUM_LAYERS
//  colour-index/valid pairs per pixel, picks the top visible layer by programmable
//  priority, falls back to background. Emits the winning index, pipeline-aligned with
//  hcount/vcount. Layer config is double-buffered and swaps only at frame start, so
//  edits never tear a frame.
// PARAMETERS
//  PIXEL_WIDTH     1280  active pixels per line
//  PIXEL_HEIGHT    720   active lines per frame
//  NUM_LAYERS      4     number of layer inputs (1..16)
//  COLOR_BITS      4     palette index width
//  PRIO_BITS       4     per-layer priority width; larger value = drawn on top
//  TRANSPARENT_IDX 4'hF  layer index value treated as "no pixel" (only when USE_TRANSPARENT=1)
//  USE_TRANSPARENT 0     1 enables transparency keying
// PORTS
//  clk_in            in   1                       system clock
//  rst_in            in   1                       reset; asynchronous, active-high
//  hcount_in         in   $clog2(PIXEL_WIDTH)     pixel x
//  vcount_in         in   $clog2(PIXEL_HEIGHT)    pixel y
//  layer_color_in    in   NUM_LAYERS*COLOR_BITS   packed; layer i at [i*COLOR_BITS +: COLOR_BITS]
//  layer_valid_in    in   NUM_LAYERS              layer i covers this pixel
//  background_in     in   COLOR_BITS              fallback index
//  cfg_valid_in      in   1                       config write request
//  cfg_ready_out     out  1                       config write accepted when valid&ready
//  cfg_layer_in      in   $clog2(NUM_LAYERS)      target layer
//  cfg_enable_in     in   1                       layer enable
//  cfg_prio_in       in   PRIO_BITS               layer priority
//  cfg_commit_in     in   1                       request shadow->active swap at next frame start
//  color_idx_out     out  COLOR_BITS              composited index (to palette)
//  hcount_out        out  $clog2(PIXEL_WIDTH)     hcount delayed to match
//  vcount_out        out  $clog2(PIXEL_HEIGHT)    vcount delayed to match
//  valid_out         out  1                       output pixel lies in active area
//  pending_out       out  1                       commit requested, swap not yet done
// BEHAVIOUR
//  - Reset (async): all outputs 0 except cfg_ready_out=1; active and shadow config:
//    every layer enabled, prio[i]=i; pending cleared. Reset mid-pending discards edits.
//  - In-active = hcount_in<PIXEL_WIDTH && vcount_in<PIXEL_HEIGHT; frame start = (0,0).
//  - Fixed latency 2: inputs sampled cycle N appear on outputs at N+2, every cycle,
//    no stalls. S1 registers inputs + qualified mask q[i]=valid[i]&en[i]&~(USE_TRANSPARENT
//    &&color[i]==TRANSPARENT_IDX). S2 registers selection result.
//  - Selection: among q[i]=1, max prio wins; equal prio -> lower layer index wins.
//    No q set -> background_in (as sampled with the pixel). valid_out=0 -> color_idx_out=0.
//  - Config: valid&ready writes shadow[cfg_layer_in]; cfg_layer_in>=NUM_LAYERS ignored
//    (still handshakes). If cfg_commit_in=1 on the accepted beat, pending<=1,
//    cfg_ready_out<=0 next cycle. Commit with out-of-range layer still commits.
//  - Swap: on the cycle frame start is sampled into S1 with pending=1, active<=shadow,
//    pending<=0, cfg_ready_out<=1 next cycle. Frame-start pixel itself uses NEW config
//    (S1 mask uses shadow on that cycle). Earlier pixels never see shadow values.
//  - Commit while frame start is on hcount/vcount in the same cycle: swap waits for next
//    frame (pending registers after sampling).
//  - No arithmetic overflow: counters pass through untouched; prio compare unsigned.
// STRUCTURE
//  - render_pkg: color_idx_t typedef, colour index constants (BLACK..LBLUE),
//    layer_cfg_t struct {en, prio}.
//  - Sub-module prio_select: combinational NUM_LAYERS-way arg-max tree over
//    {q, prio} returning winner index + any_hit; lower index wins ties.
//  - layer_compositor: S1/S2 regs, shadow/active cfg banks, pending FSM (IDLE/PENDING).
// TESTING
//  1 Reset defaults: layers 0..3 all valid, colours 3,5,7,9 -> color_idx_out=9 at N+2.
//  2 Tie: prio all 2 via commit, layers 1,3 valid (colours 5,9) -> out 5; none valid,
//    background 2 -> out 2; hcount 1280 -> valid_out=0, out 0.
//  3 Tear-free: commit disable layer3 mid-frame (pixel 500,300) -> pending_out=1,
//    ready=0, layer3 still shown until (0,0); pixel (0,0) onward shows layer2 colour 7.
//  4 Transparency (USE_TRANSPARENT=1): layer3 colour F, layer2 colour 7 -> out 7.
//  5 Async reset asserted while pending, mid-line -> outputs 0 same cycle, pending 0,
//    ready 1, defaults restored after release.
//  6 Randomised 2 frames vs. scoreboard model; latency always exactly 2 cycles.

Source files
------------

// File: rtl/render_pkg.sv
// render_pkg: shared rendering types for the compositor slice.
//  - color_idx_t      : 4-bit palette index
//  - BLACK..LBLUE     : named palette indices
//  - layer_cfg_t      : per-layer {en, prio} record
//  - cfg_state_t      : config-commit FSM states
//  - idx_bits()       : index width that never collapses to zero bits
package render_pkg;

  localparam int PRIO_W = 4;

  typedef logic [3:0] color_idx_t;

  localparam color_idx_t BLACK   = 4'd0;
  localparam color_idx_t BLUE    = 4'd1;
  localparam color_idx_t GREEN   = 4'd2;
  localparam color_idx_t CYAN    = 4'd3;
  localparam color_idx_t RED     = 4'd4;
  localparam color_idx_t MAGENTA = 4'd5;
  localparam color_idx_t BROWN   = 4'd6;
  localparam color_idx_t LGRAY   = 4'd7;
  localparam color_idx_t DGRAY   = 4'd8;
  localparam color_idx_t LBLUE   = 4'd9;

  typedef struct packed {
    logic              en;
    logic [PRIO_W-1:0] prio;
  } layer_cfg_t;

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

  // A single layer still needs a 1-bit select/index port.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_select.sv
// prio_select: combinational arg-max over NUM_LAYERS {q, prio} pairs.
//  q        in   NUM_LAYERS             qualified hit per layer
//  prio     in   NUM_LAYERS x PRIO_BITS priority per layer (unsigned, larger wins)
//  win_idx  out  IDX_BITS               winning layer (don't-care when any_hit=0)
//  any_hit  out  1                      at least one q bit set
// Balanced binary tree over a power-of-two padded leaf set; left children hold
// lower layer indices, so ">=" on the left side resolves ties to the lower index.
module prio_select
  import render_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int PRIO_BITS  = 4,
  parameter int IDX_BITS   = idx_bits(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0]                q,
  input  logic [NUM_LAYERS-1:0][PRIO_BITS-1:0] prio,
  output logic [IDX_BITS-1:0]                  win_idx,
  output logic                                 any_hit
);

  localparam int NP = 1 << $clog2(NUM_LAYERS);

  always_comb begin : tree
    // heap layout: node k has children 2k, 2k+1; leaves at NP..2*NP-1
    logic [2*NP-1:1]                hit;
    logic [2*NP-1:1][PRIO_BITS-1:0] pr;
    logic [2*NP-1:1][IDX_BITS-1:0]  ix;
    logic                           take_left;
    hit       = '0;
    pr        = '0;
    ix        = '0;
    take_left = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      hit[NP+i] = q[i];
      pr[NP+i]  = prio[i];
      ix[NP+i]  = IDX_BITS'(i);
    end
    for (int k = NP - 1; k >= 1; k--) begin
      take_left = hit[2*k] && (!hit[2*k+1] || (pr[2*k] >= pr[2*k+1]));
      hit[k]    = hit[2*k] | hit[2*k+1];
      pr[k]     = take_left ? pr[2*k] : pr[2*k+1];
      ix[k]     = take_left ? ix[2*k] : ix[2*k+1];
    end
    win_idx = ix[1];
    any_hit = hit[1];
  end

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: per-pixel layer compositor feeding the palette.
//  clk_in, rst_in            clock, async active-high reset
//  hcount_in/vcount_in       pixel position
//  layer_color_in/valid_in   packed per-layer colour index + coverage
//  background_in             fallback colour when no layer hits
//  cfg_*                     shadow-config write port (valid/ready) + commit
//  color_idx_out             composited index, 2 cycles after the inputs
//  hcount_out/vcount_out     position aligned with color_idx_out
//  valid_out                 output pixel is inside the active area
//  pending_out               commit waiting for the next frame start
// S1 registers the pixel plus the qualified layer mask; S2 registers the
// arg-max result. Config edits land in a shadow bank that is copied into the
// active bank only as frame start (0,0) enters S1.
module layer_compositor
  import render_pkg::*;
#(
  parameter int                     PIXEL_WIDTH     = 1280,
  parameter int                     PIXEL_HEIGHT    = 720,
  parameter int                     NUM_LAYERS      = 4,
  parameter int                     COLOR_BITS      = 4,
  parameter int                     PRIO_BITS       = 4,
  parameter logic [COLOR_BITS-1:0]  TRANSPARENT_IDX = {COLOR_BITS{1'b1}},
  parameter bit                     USE_TRANSPARENT = 1'b0
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [$clog2(PIXEL_WIDTH)-1:0]     hcount_in,
  input  logic [$clog2(PIXEL_HEIGHT)-1:0]    vcount_in,
  input  logic [NUM_LAYERS*COLOR_BITS-1:0]   layer_color_in,
  input  logic [NUM_LAYERS-1:0]              layer_valid_in,
  input  logic [COLOR_BITS-1:0]              background_in,
  input  logic                               cfg_valid_in,
  output logic                               cfg_ready_out,
  input  logic [idx_bits(NUM_LAYERS)-1:0]    cfg_layer_in,
  input  logic                               cfg_enable_in,
  input  logic [PRIO_BITS-1:0]               cfg_prio_in,
  input  logic                               cfg_commit_in,
  output logic [COLOR_BITS-1:0]              color_idx_out,
  output logic [$clog2(PIXEL_WIDTH)-1:0]     hcount_out,
  output logic [$clog2(PIXEL_HEIGHT)-1:0]    vcount_out,
  output logic                               valid_out,
  output logic                               pending_out
);

  localparam int HW     = $clog2(PIXEL_WIDTH);
  localparam int VW     = $clog2(PIXEL_HEIGHT);
  localparam int LW     = idx_bits(NUM_LAYERS);
  localparam int STAGES = 2;

  // ---------------- config banks + commit FSM ----------------
  cfg_state_t                            state, state_nxt;
  logic [NUM_LAYERS-1:0]                 shadow_en, active_en;
  logic [NUM_LAYERS-1:0][PRIO_BITS-1:0]  shadow_prio, active_prio;
  logic                                  frame_start, cfg_fire, swap;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);
  assign cfg_fire    = cfg_valid_in & cfg_ready_out;
  // Only possible in PENDING, where ready=0, so never coincides with a write.
  assign swap        = (state == CFG_PENDING) && frame_start;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= CFG_IDLE;
    else        state <= state_nxt;
  end

  // A commit accepted while (0,0) is on the inputs is registered after that
  // pixel was sampled, so the swap naturally waits for the following frame.
  always_comb begin
    state_nxt = state;
    case (state)
      CFG_IDLE:    if (cfg_fire && cfg_commit_in) state_nxt = CFG_PENDING;
      CFG_PENDING: if (frame_start)               state_nxt = CFG_IDLE;
      default:                                    state_nxt = CFG_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_out = (state == CFG_IDLE);
    pending_out   = (state == CFG_PENDING);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_en[i]   <= 1'b1;
        shadow_prio[i] <= PRIO_BITS'(i);
        active_en[i]   <= 1'b1;
        active_prio[i] <= PRIO_BITS'(i);
      end
    end else begin
      // Out-of-range layer numbers match no entry and are dropped silently.
      if (cfg_fire) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (cfg_layer_in == LW'(i)) begin
            shadow_en[i]   <= cfg_enable_in;
            shadow_prio[i] <= cfg_prio_in;
          end
        end
      end
      if (swap) begin
        active_en   <= shadow_en;
        active_prio <= shadow_prio;
      end
    end
  end

  // ---------------- S1: sample pixel + qualify layers ----------------
  logic [NUM_LAYERS-1:0]               cur_en, q_nxt;
  logic                                in_active;

  assign in_active = ({1'b0, hcount_in} < (HW+1)'(PIXEL_WIDTH)) &&
                     ({1'b0, vcount_in} < (VW+1)'(PIXEL_HEIGHT));

  // The frame-start pixel is qualified with the incoming bank.
  always_comb begin
    cur_en = swap ? shadow_en : active_en;
    q_nxt  = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      q_nxt[i] = layer_valid_in[i] & cur_en[i] &
                 ~(USE_TRANSPARENT &&
                   (layer_color_in[i*COLOR_BITS +: COLOR_BITS] == TRANSPARENT_IDX));
    end
  end

  logic [STAGES:1]                    vld_pipe;
  logic [NUM_LAYERS*COLOR_BITS-1:0]   s1_color;
  logic [NUM_LAYERS-1:0]              s1_mask;
  logic [COLOR_BITS-1:0]              s1_bg;
  logic [HW-1:0]                      s1_h;
  logic [VW-1:0]                      s1_v;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_color <= '0;
      s1_mask  <= '0;
      s1_bg    <= '0;
      s1_h     <= '0;
      s1_v     <= '0;
    end else begin
      s1_color <= layer_color_in;
      s1_mask  <= q_nxt;
      s1_bg    <= background_in;
      s1_h     <= hcount_in;
      s1_v     <= vcount_in;
    end
  end

  // ---------------- S2: select winner ----------------
  // active_prio is safe to read here: the bank only changes as the frame-start
  // pixel enters S1, and that pixel was already qualified with the new bank.
  logic [LW-1:0]         win_idx;
  logic                  any_hit;
  logic [COLOR_BITS-1:0] sel_color;

  prio_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .PRIO_BITS  (PRIO_BITS),
    .IDX_BITS   (LW)
  ) u_sel (
    .q       (s1_mask),
    .prio    (active_prio),
    .win_idx (win_idx),
    .any_hit (any_hit)
  );

  always_comb begin
    sel_color = s1_bg;
    if (any_hit) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (win_idx == LW'(i)) sel_color = s1_color[i*COLOR_BITS +: COLOR_BITS];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_pipe      <= '0;
      color_idx_out <= '0;
      hcount_out    <= '0;
      vcount_out    <= '0;
    end else begin
      vld_pipe      <= {vld_pipe[STAGES-1:1], in_active};
      color_idx_out <= vld_pipe[1] ? sel_color : '0;
      hcount_out    <= s1_h;
      vcount_out    <= s1_v;
    end
  end

  assign valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed vector table, hand-written sequences
// for commit/swap/reset timing, and a randomised run against a scoreboard.
// Two instances share stimulus: u_dut0 (transparency off), u_dut1 (on).
module tb_layer_compositor;
  import render_pkg::*;

  logic        clk, rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [15:0] lcol;
  logic [3:0]  lvld, bg;
  logic        cfg_valid, cfg_en, cfg_commit;
  logic [1:0]  cfg_layer;
  logic [3:0]  cfg_prio;

  logic        rdy0, val0, pend0, rdy1, val1, pend1;
  logic [3:0]  col0, col1;
  logic [10:0] hout0, hout1;
  logic [9:0]  vout0, vout1;

  int checks = 0;
  int errors = 0;

  layer_compositor u_dut0 (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .layer_color_in(lcol), .layer_valid_in(lvld), .background_in(bg),
    .cfg_valid_in(cfg_valid), .cfg_ready_out(rdy0), .cfg_layer_in(cfg_layer),
    .cfg_enable_in(cfg_en), .cfg_prio_in(cfg_prio), .cfg_commit_in(cfg_commit),
    .color_idx_out(col0), .hcount_out(hout0), .vcount_out(vout0),
    .valid_out(val0), .pending_out(pend0));

  layer_compositor #(.USE_TRANSPARENT(1'b1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .layer_color_in(lcol), .layer_valid_in(lvld), .background_in(bg),
    .cfg_valid_in(cfg_valid), .cfg_ready_out(rdy1), .cfg_layer_in(cfg_layer),
    .cfg_enable_in(cfg_en), .cfg_prio_in(cfg_prio), .cfg_commit_in(cfg_commit),
    .color_idx_out(col1), .hcount_out(hout1), .vcount_out(vout1),
    .valid_out(val1), .pending_out(pend1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  v;
    logic [15:0] col;
    logic [3:0]  bgc;
    int          hc;
    int          vc;
    logic [3:0]  e0;   // expected, transparency off
    logic [3:0]  e1;   // expected, transparency on
    bit          ev;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int h, input int v, input logic [3:0] vl,
                       input logic [15:0] c, input logic [3:0] b);
    hcount = 11'(h); vcount = 10'(v); lvld = vl; lcol = c; bg = b;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic cfg_write(input int layer, input bit en, input logic [3:0] pr, input bit commit);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_layer = layer[1:0]; cfg_en = en; cfg_prio = pr; cfg_commit = commit;
    while (!rdy0 && n < 20) begin tick(); n++; end
    chk("cfg_ready wait", rdy0, 1'b1);
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic run_vec(input int i);
    drive(tbl[i].hc, tbl[i].vc, tbl[i].v, tbl[i].col, tbl[i].bgc);
    tick(); tick();
    chk($sformatf("vec%0d color0", i), col0, tbl[i].e0);
    chk($sformatf("vec%0d color1", i), col1, tbl[i].e1);
    chk($sformatf("vec%0d valid", i), val0, tbl[i].ev);
    chk($sformatf("vec%0d hv_out", i), {hout0, vout0}, {11'(tbl[i].hc), 10'(tbl[i].vc)});
  endtask

  // Scoreboard model: linear scan, strict ">" keeps the lower index on ties.
  function automatic logic [3:0] model_pix(input logic [3:0] v, input logic [15:0] c,
      input logic [3:0] b, input int h, input int vv, input logic [3:0] en,
      input logic [3:0][3:0] pr, input bit tr);
    int best;
    best = -1;
    if (h >= 1280 || vv >= 720) return 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && en[i] && !(tr && c[i*4 +: 4] == 4'hF)) begin
        if (best < 0) best = i;
        else if (pr[i] > pr[best]) best = i;
      end
    end
    return (best < 0) ? b : c[best*4 +: 4];
  endfunction

  logic [3:0]      m_sen, m_aen, u_en;
  logic [3:0][3:0] m_spr, m_apr, u_pr;
  bit              m_pend;
  logic [31:0]     q0[$], q1[$];

  initial begin
    // layer3..0 colours: 9 7 5 3 unless noted
    tbl[0]  = '{4'hF, 16'h9753, 4'h2, 100,  50,  LBLUE,   LBLUE,   1'b1};
    tbl[1]  = '{4'h7, 16'h9753, 4'h2, 100,  50,  LGRAY,   LGRAY,   1'b1};
    tbl[2]  = '{4'h0, 16'h9753, 4'h2, 100,  50,  GREEN,   GREEN,   1'b1};
    tbl[3]  = '{4'h1, 16'h9753, 4'h2, 100,  50,  CYAN,    CYAN,    1'b1};
    tbl[4]  = '{4'hF, 16'h9753, 4'h2, 1280, 50,  BLACK,   BLACK,   1'b0};
    tbl[5]  = '{4'hF, 16'h9753, 4'h2, 5,    720, BLACK,   BLACK,   1'b0};
    tbl[6]  = '{4'hA, 16'h9753, 4'h2, 1279, 719, LBLUE,   LBLUE,   1'b1};
    tbl[7]  = '{4'hC, 16'hF753, 4'h2, 200,  10,  4'hF,    LGRAY,   1'b1};
    tbl[8]  = '{4'h0, 16'h9753, 4'h6, 3,    0,   BROWN,   BROWN,   1'b1};
    // after commit of prio=2 on every layer
    tbl[9]  = '{4'hA, 16'h9753, 4'h2, 10,   10,  MAGENTA, MAGENTA, 1'b1};
    tbl[10] = '{4'h0, 16'h9753, 4'h2, 10,   10,  GREEN,   GREEN,   1'b1};
    tbl[11] = '{4'hF, 16'h9753, 4'h2, 1280, 10,  BLACK,   BLACK,   1'b0};
    tbl[12] = '{4'hF, 16'h9753, 4'h2, 10,   10,  CYAN,    CYAN,    1'b1};
    tbl[13] = '{4'hC, 16'hF753, 4'h2, 10,   10,  LGRAY,   LGRAY,   1'b1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_layer = '0; cfg_en = 1'b0; cfg_prio = '0; cfg_commit = 1'b0;
    drive(100, 50, 4'h0, 16'h0, 4'h0);
    tick(); tick();
    chk("reset color", col0, 0);
    chk("reset valid", val0, 0);
    chk("reset hv_out", {hout0, vout0}, 0);
    chk("reset ready", rdy0, 1);
    chk("reset pending", pend0, 0);
    rst = 1'b0;

    // ---- defaults (prio[i]=i, all enabled) ----
    for (int i = 0; i <= 8; i++) run_vec(i);

    // ---- commit prio 2 everywhere; old config holds until frame start ----
    drive(10, 10, 4'hA, 16'h9753, 4'h2);
    cfg_write(0, 1'b1, 4'd2, 1'b0);
    cfg_write(1, 1'b1, 4'd2, 1'b0);
    cfg_write(2, 1'b1, 4'd2, 1'b0);
    cfg_write(3, 1'b1, 4'd2, 1'b1);
    chk("B pending set", pend0, 1);
    chk("B ready low", rdy0, 0);
    tick(); tick();
    chk("B pre-swap color", col0, LBLUE);
    drive(0, 0, 4'hA, 16'h9753, 4'h2);
    tick();
    chk("B swap pending clr", pend0, 0);
    chk("B swap ready", rdy0, 1);
    drive(1, 0, 4'hA, 16'h9753, 4'h2);
    tick();
    chk("B frame-start color", col0, MAGENTA);
    chk("B frame-start hv", {hout0, vout0}, 0);
    for (int i = 9; i <= 13; i++) run_vec(i);

    // ---- tear-free disable of layer 3 mid-frame ----
    reset_pulse();
    drive(500, 300, 4'hF, 16'h9753, 4'h2);
    cfg_write(3, 1'b0, 4'd3, 1'b1);
    chk("C pending", pend0, 1);
    chk("C ready", rdy0, 0);
    tick(); tick();
    chk("C mid-frame color", col0, LBLUE);
    drive(1279, 719, 4'hF, 16'h9753, 4'h2);
    tick();
    drive(0, 0, 4'hF, 16'h9753, 4'h2);
    tick();
    chk("C last pixel color", col0, LBLUE);
    chk("C last pixel hv", {hout0, vout0}, {11'd1279, 10'd719});
    chk("C swap pending clr", pend0, 0);
    drive(1, 0, 4'hF, 16'h9753, 4'h2);
    tick();
    chk("C frame-start color", col0, LGRAY);
    chk("C frame-start hv", {hout0, vout0}, 0);
    drive(2, 0, 4'hF, 16'h9753, 4'h2);
    tick();
    chk("C next color", col0, LGRAY);

    // ---- commit accepted while (0,0) is sampled waits a whole frame ----
    drive(0, 0, 4'hF, 16'h9753, 4'h2);
    cfg_write(3, 1'b1, 4'd3, 1'b1);
    chk("D pending", pend0, 1);
    drive(1, 0, 4'hF, 16'h9753, 4'h2);
    tick(); tick();
    chk("D still old color", col0, LGRAY);
    chk("D still pending", pend0, 1);
    drive(0, 0, 4'hF, 16'h9753, 4'h2);
    tick();
    drive(1, 0, 4'hF, 16'h9753, 4'h2);
    tick();
    chk("D new frame color", col0, LBLUE);
    chk("D pending clr", pend0, 0);

    // ---- async reset while pending, mid-cycle ----
    drive(600, 100, 4'hF, 16'h9753, 4'h2);
    cfg_write(3, 1'b0, 4'd3, 1'b1);
    chk("E pending", pend0, 1);
    tick(); tick();
    chk("E pre-reset color", col0, LBLUE);
    #3 rst = 1'b1;
    #1;
    chk("E async color", col0, 0);
    chk("E async valid", val0, 0);
    chk("E async hv", {hout0, vout0}, 0);
    chk("E async pending", pend0, 0);
    chk("E async ready", rdy0, 1);
    #2 rst = 1'b0;
    tick(); tick();
    chk("E default color", col0, LBLUE);
    chk("E default hv", {hout0, vout0}, {11'd600, 10'd100});
    drive(0, 0, 4'hF, 16'h9753, 4'h2);
    tick();
    drive(1, 0, 4'hF, 16'h9753, 4'h2);
    tick();
    chk("E edits discarded", col0, LBLUE);
    chk("E no pending", pend0, 0);

    // ---- transparency keying: F on top layer ----
    drive(40, 40, 4'hC, 16'hF753, 4'h2);
    tick(); tick();
    chk("F opaque dut0", col0, 4'hF);
    chk("F keyed dut1", col1, LGRAY);

    // ---- randomised run against scoreboard ----
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      m_sen[i] = 1'b1; m_aen[i] = 1'b1; m_spr[i] = 4'(i); m_apr[i] = 4'(i);
    end
    m_pend = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      int h, v;
      bit fs, fire;
      h = $urandom_range(0, 1300);
      v = $urandom_range(0, 730);
      if (n == 700 || n == 1400 || $urandom_range(0, 49) == 0) begin h = 0; v = 0; end
      drive(h, v, 4'($urandom), 16'($urandom), 4'($urandom));
      cfg_valid  = ($urandom_range(0, 9) == 0);
      cfg_layer  = 2'($urandom);
      cfg_en     = 1'($urandom);
      cfg_prio   = 4'($urandom);
      cfg_commit = ($urandom_range(0, 2) == 0);
      fs = (h == 0 && v == 0);
      chk("R ready", rdy0, !m_pend);
      chk("R pending", pend0, m_pend);
      u_en = (m_pend && fs) ? m_sen : m_aen;
      u_pr = (m_pend && fs) ? m_spr : m_apr;
      q0.push_back({6'd0, (h < 1280 && v < 720), 11'(h), 10'(v),
                    model_pix(lvld, lcol, bg, h, v, u_en, u_pr, 1'b0)});
      q1.push_back({6'd0, (h < 1280 && v < 720), 11'(h), 10'(v),
                    model_pix(lvld, lcol, bg, h, v, u_en, u_pr, 1'b1)});
      fire = cfg_valid && !m_pend;
      if (m_pend && fs) begin
        m_aen = m_sen; m_apr = m_spr; m_pend = 1'b0;
      end else if (fire) begin
        m_sen[cfg_layer] = cfg_en;
        m_spr[cfg_layer] = cfg_prio;
        if (cfg_commit) m_pend = 1'b1;
      end
      tick();
      if (q0.size() == 2) begin
        chk("R pixel dut0", {6'd0, val0, hout0, vout0, col0}, q0.pop_front());
        chk("R pixel dut1", {6'd0, val1, hout1, vout1, col1}, q1.pop_front());
      end
    end
    cfg_valid = 1'b0; cfg_commit = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
